// File: rtl/bitsplit_pkg.sv
// Shared types and constants for the bit splitter and its downstream even/odd SIPO.
package bitsplit_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WORD_W = 8;

  // Lane-select encoding on outt, interpreted identically by the SIPO.
  localparam logic LANE_EVE = 1'b0;
  localparam logic LANE_ODD = 1'b1;

endpackage

// File: rtl/bit_splitter.sv
// Serialises a parallel word one bit per clock onto alternating even/odd lanes.
// Optional MSB_FIRST_EN macro: present in_data MSB first instead of LSB first.
module bit_splitter
  import bitsplit_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int CNT_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              dataeve,
  output logic              dataodd,
  output logic              outt,
  output logic              bit_valid,
  output logic              frame_done
);

  if ((WORD_W < 2) || ((WORD_W % 2) != 0)) begin : g_bad_word_w
    $error("bit_splitter: WORD_W must be even and >= 2");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

  // Bit leaving the shift register next.
  function automatic logic head_bit(input logic [WORD_W-1:0] w);
`ifdef MSB_FIRST_EN
    return w[WORD_W-1];
`else
    return w[0];
`endif
  endfunction

  // Shift register contents after one bit has been presented.
  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
`ifdef MSB_FIRST_EN
    return {w[WORD_W-2:0], 1'b0};
`else
    return {1'b0, w[WORD_W-1:1]};
`endif
  endfunction

  state_e            state_r;
  state_e            next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [WORD_W-1:0] shreg_r;
  logic [WORD_W-1:0] shreg_nxt_s;
  logic              dataeve_nxt_s;
  logic              dataodd_nxt_s;
  logic              outt_nxt_s;
  logic              bit_valid_nxt_s;
  logic              frame_done_nxt_s;
  logic              last_s;
  logic              accept_s;

  // cnt_r is the index of the bit currently on the outputs.
  assign last_s    = (state_r == SHIFT) && (cnt_r == LAST_CNT);
  assign in_ready  = (state_r == IDLE) || last_s;
  assign accept_s  = in_valid && in_ready;
  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Next-state and next-output decode.
  always_comb begin
    next_state_s     = state_r;
    cnt_nxt_s        = cnt_r;
    shreg_nxt_s      = shreg_r;
    dataeve_nxt_s    = dataeve;
    dataodd_nxt_s    = dataodd;
    outt_nxt_s       = outt;
    bit_valid_nxt_s  = 1'b0;
    frame_done_nxt_s = 1'b0;
    if (accept_s) begin
      // Also covers the back-to-back case on the last-bit cycle.
      next_state_s    = SHIFT;
      cnt_nxt_s       = {CNT_W{1'b0}};
      shreg_nxt_s     = advance(in_data);
      dataeve_nxt_s   = head_bit(in_data);
      outt_nxt_s      = LANE_EVE;
      bit_valid_nxt_s = 1'b1;
    end else if ((state_r == SHIFT) && !last_s) begin
      cnt_nxt_s        = cnt_inc_s;
      shreg_nxt_s      = advance(shreg_r);
      outt_nxt_s       = cnt_inc_s[0];
      bit_valid_nxt_s  = 1'b1;
      frame_done_nxt_s = (cnt_inc_s == LAST_CNT);
      if (cnt_inc_s[0] == LANE_ODD) begin
        dataodd_nxt_s = head_bit(shreg_r);
      end else begin
        dataeve_nxt_s = head_bit(shreg_r);
      end
    end else if (state_r == SHIFT) begin
      next_state_s = IDLE;
    end else begin
      next_state_s = IDLE;
    end
  end

  // State, counter, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      shreg_r    <= {WORD_W{1'b0}};
      dataeve    <= 1'b0;
      dataodd    <= 1'b0;
      outt       <= 1'b0;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      cnt_r      <= cnt_nxt_s;
      shreg_r    <= shreg_nxt_s;
      dataeve    <= dataeve_nxt_s;
      dataodd    <= dataodd_nxt_s;
      outt       <= outt_nxt_s;
      bit_valid  <= bit_valid_nxt_s;
      frame_done <= frame_done_nxt_s;
    end
  end

endmodule

// File: tb/tb_bit_splitter.sv
// Directed, table-driven bench for bit_splitter (WORD_W=8 and WORD_W=4 instances).
module tb_bit_splitter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       dataeve, dataodd, outt, bit_valid, frame_done;

  logic       in_valid4;
  logic       in_ready4;
  logic [3:0] in_data4;
  logic       dataeve4, dataodd4, outt4, bit_valid4, frame_done4;

  int tests_run = 0;
  int tests_failed = 0;

  logic       eve_m, odd_m;
  logic [3:0] sipo_eve, sipo_odd;

  bit_splitter #(.WORD_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .dataeve(dataeve), .dataodd(dataodd), .outt(outt),
    .bit_valid(bit_valid), .frame_done(frame_done)
  );

  bit_splitter #(.WORD_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .dataeve(dataeve4), .dataodd(dataodd4), .outt(outt4),
    .bit_valid(bit_valid4), .frame_done(frame_done4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_lsb;  // bit k = bit presented in cycle k, LSB-first build
    logic [7:0] exp_msb;  // same, MSB-first build
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick(input vec_t v);
`ifdef MSB_FIRST_EN
    return v.exp_msb;
`else
    return v.exp_lsb;
`endif
  endfunction

  // One presented-bit cycle of the 8-bit DUT, sampled on the falling edge.
  task automatic check_bit(input int k, input logic b);
    logic last;
    last = (k == 7);
    chk("bit_valid", bit_valid, 1);
    chk("outt", outt, k % 2);
    if ((k % 2) == 0) begin
      chk("dataeve", dataeve, b);
      chk("dataodd_hold", dataodd, odd_m);
      eve_m = b;
      sipo_eve = {b, sipo_eve[3:1]};
    end else begin
      chk("dataodd", dataodd, b);
      chk("dataeve_hold", dataeve, eve_m);
      odd_m = b;
      sipo_odd = {b, sipo_odd[3:1]};
    end
    chk("frame_done", frame_done, last);
    chk("in_ready", in_ready, last);
  endtask

  task automatic check_idle(input logic exp_outt);
    chk("idle_bit_valid", bit_valid, 0);
    chk("idle_frame_done", frame_done, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_outt", outt, exp_outt);
    chk("idle_dataeve", dataeve, eve_m);
    chk("idle_dataodd", dataodd, odd_m);
  endtask

  // Accept one word from idle and check all eight cycles plus the return to idle.
  task automatic run_word(input logic [7:0] data, input logic [7:0] exp);
    in_valid = 1'b1;
    in_data  = data;
    chk("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_bit(k, exp[k]);
      @(negedge clk);
    end
    check_idle(1'b1);
  endtask

  initial begin
    logic [15:0] exp16;
    vec_t v;

    vecs[0] = '{data: 8'hA5, exp_lsb: 8'hA5, exp_msb: 8'hA5};
    vecs[1] = '{data: 8'h01, exp_lsb: 8'h01, exp_msb: 8'h80};
    vecs[2] = '{data: 8'h80, exp_lsb: 8'h80, exp_msb: 8'h01};
    vecs[3] = '{data: 8'h3C, exp_lsb: 8'h3C, exp_msb: 8'h3C};
    vecs[4] = '{data: 8'h96, exp_lsb: 8'h96, exp_msb: 8'h69};
    vecs[5] = '{data: 8'hFF, exp_lsb: 8'hFF, exp_msb: 8'hFF};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_valid4 = 1'b0;
    in_data4  = 4'h0;
    eve_m = 1'b0; odd_m = 1'b0;
    sipo_eve = 4'h0; sipo_odd = 4'h0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_outt", outt, 0);
    chk("rst_dataeve", dataeve, 0);
    chk("rst_dataodd", dataodd, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // 8'hB4 with the chained SIPO picture
    v = '{data: 8'hB4, exp_lsb: 8'hB4, exp_msb: 8'h2D};
    run_word(v.data, pick(v));
`ifndef MSB_FIRST_EN
    chk("sipo_outeve", sipo_eve, 4'b0110);
    chk("sipo_outodd", sipo_odd, 4'b1100);
`endif

    // Table of single words
    for (int i = 0; i < 6; i++) begin
      run_word(vecs[i].data, pick(vecs[i]));
    end

    // Back-to-back FF then 00 with in_valid held high
    exp16 = 16'h00FF;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    in_data = 8'h00;
    for (int k = 0; k < 16; k++) begin
      check_bit(k % 8, exp16[k]);
      if (k == 8) in_valid = 1'b0;
      @(negedge clk);
    end
    check_idle(1'b1);

    // in_valid raised mid-word: A5 must finish untouched, 5A follows on the last bit
    exp16 = 16'h5AA5;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        in_valid = 1'b1;
        in_data  = 8'h5A;
      end
      check_bit(k % 8, exp16[k]);
      if (k == 8) in_valid = 1'b0;
      @(negedge clk);
    end
    check_idle(1'b1);

    // Asynchronous reset at bit 4 of 8'h3C
    v = vecs[3];
    in_valid = 1'b1;
    in_data  = v.data;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_bit(k, pick(v)[k]);
      @(negedge clk);
    end
    chk("pre_rst_bit_valid", bit_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_bit_valid", bit_valid, 0);
    chk("arst_outt", outt, 0);
    chk("arst_dataeve", dataeve, 0);
    chk("arst_dataodd", dataodd, 0);
    chk("arst_frame_done", frame_done, 0);
    eve_m = 1'b0; odd_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("post_rst_frame_done", frame_done, 0);
      chk("post_rst_bit_valid", bit_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
      @(negedge clk);
    end
    v = vecs[1];
    run_word(v.data, pick(v));

    // WORD_W=4 instance, 4'b1001 is its own reverse so both builds agree
    in_valid4 = 1'b1;
    in_data4  = 4'b1001;
    chk("w4_ready", in_ready4, 1);
    @(negedge clk);
    in_valid4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("w4_bit_valid", bit_valid4, 1);
      chk("w4_outt", outt4, k % 2);
      if ((k % 2) == 0) chk("w4_dataeve", dataeve4, (k == 0) ? 1 : 0);
      else              chk("w4_dataodd", dataodd4, (k == 3) ? 1 : 0);
      chk("w4_frame_done", frame_done4, (k == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("w4_idle_bit_valid", bit_valid4, 0);
    chk("w4_idle_frame_done", frame_done4, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bit_splitter.md
Name: bit_splitter

Overview:
- Upstream feeder for the even/odd SIPO deserialiser.
- Accepts a parallel word over a valid/ready handshake and serialises it one bit per clock.
- Even-indexed bits go to the even lane and odd-indexed bits go to the odd lane.
- Drives `outt`, the lane-select, so the downstream SIPO fills `outeve` when `outt`=0 and `outodd` when `outt`=1.

Parameters:
- `WORD_W`, 8, input word width. Must be even and ≥2; otherwise elaboration fails via a generate-time error.
- `CNT_W`, `$clog2(WORD_W)`, bit-counter width. Derived; do not override.

Ports:
- `clk`  input  1  rising-edge clock
- `reset_n`  input  1  asynchronous active-low reset
- `in_valid`  input  1  `in_data` is valid
- `in_ready`  output  1  block can accept a word this cycle
- `in_data`  input  `WORD_W`  parallel word to split
- `dataeve`  output  1  even-lane bit, to SIPO `dataeve`
- `dataodd`  output  1  odd-lane bit, to SIPO `dataodd`
- `outt`  output  1  lane select: 0 = even lane active, 1 = odd lane active
- `bit_valid`  output  1  a new bit is presented this cycle
- `frame_done`  output  1  one-cycle pulse coinciding with the last bit of a word

Behaviour:
- Reset
  - `reset_n` low: state=IDLE; shift register, counter, `dataeve`, `dataodd`, `outt`, `bit_valid`, `frame_done` all 0.
  - Takes effect immediately (asynchronous) and aborts any word in flight; no partial-word completion afterwards.
- States
  - IDLE: `in_ready`=1.
  - SHIFT: `in_ready`=1 only in the last-bit cycle (`cnt`==`WORD_W`-1), giving back-to-back support.
  - `in_ready` is combinational from state and `cnt`.
- Accept
  - Occurs at a rising edge where `in_valid` && `in_ready`.
  - Loads `shreg`←`in_data`, `cnt`←0, state→SHIFT.
  - `in_data` is not sampled at any other time.
- Serialisation
  - Outputs are registered. The cycle after the accept edge shows bit 0.
  - Each SHIFT cycle k (k=0..`WORD_W`-1): `bit_valid`=1, `outt`=k[0].
    - k even: `dataeve`=bit k. k odd: `dataodd`=bit k.
    - The inactive lane holds its previous value.
  - Bit order is LSB first by default.
  - Latency: first bit 1 cycle after accept; a word takes exactly `WORD_W` cycles.
- Last bit (k=`WORD_W`-1, always odd because `WORD_W` is even)
  - `frame_done`=1 for that cycle only.
  - If a new accept happens at that edge: next cycle is bit 0 of the new word, with no bubble, `frame_done` drops and `outt` returns to 0.
  - Otherwise: state→IDLE, `bit_valid`=0, `outt` and both lanes hold their last values.
- Counter: `cnt` increments by 1 with no wrap inside a word; it is reloaded to 0 on accept.
- Simultaneous events
  - `in_valid` during SHIFT and not the last bit: ignored (`in_ready`=0); the source must hold the word.
  - `reset_n` low together with `in_valid`: reset wins.

Optional Feature:
- `MSB_FIRST_EN`
- Defined: bit k presented = `in_data`[`WORD_W`-1-k]; lane assignment still follows k parity (first-sent bit on even lane).
- Undefined: LSB first as above. Handshake, timing and `frame_done` are identical in both builds.

Decomposition:
- Package `bitsplit_pkg`:
  - state enum {IDLE, SHIFT}
  - `DEFAULT_WORD_W`=8
  - lane-select encoding constants `LANE_EVE`=1'b0, `LANE_ODD`=1'b1 (shared with the SIPO's `outt` interpretation).
- No sub-module needed: the counter and shift register are inline.

Test Plan:
- Reset, then `in_data`=8'hB4, `in_valid` 1 cycle:
  - next 8 cycles `outt`=0,1,0,1,0,1,0,1; presented bits 0,0,1,0,1,1,0,1; `frame_done` only on the 8th cycle.
  - Chained SIPO ends with `outeve`=4'b0110, `outodd`=4'b1100.
- Back-to-back 8'hFF then 8'h00, `in_valid` held high:
  - second accept on the last-bit cycle; 16 consecutive `bit_valid` cycles; lanes go 1s then 0s; no bubble.
- `in_valid` asserted mid-word (cycle 3 of 8'hA5):
  - `in_ready`=0, second word not accepted until the last-bit cycle; first word's output unaltered.
- `reset_n` pulsed low at bit 4 of 8'h3C:
  - all outputs 0 immediately, `in_ready`=1 after release, no `frame_done`, next word 8'h01 serialises cleanly.
- `MSB_FIRST_EN` build, `in_data`=8'h80:
  - first cycle `dataeve`=1, `outt`=0; all remaining presented bits 0.
- `WORD_W`=4, `in_data`=4'b1001:
  - 4-cycle word, presented bits 1,0,0,1; `frame_done` on the 4th cycle; `WORD_W`=5 fails elaboration.
